// File: rtl/pc_next_seq_if.sv
// Decoded-control inputs and status outputs of the next-PC sequencer.
// The slave modport is the sequencer's view; the master drives the controls.
interface pc_next_seq_if #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic [AW-1:0]  i_pc;
  logic [2:0]     i_op;
  logic [AW-1:0]  i_target;
  logic           i_zero;
  logic           i_stall;
  logic [AW-1:0]  o_pc_add;
  logic           o_halted;
  logic [SPW-1:0] o_sp;
  logic           o_ovf;
  logic           o_unf;

  modport slave (
    input  i_pc, i_op, i_target, i_zero, i_stall,
    output o_pc_add, o_halted, o_sp, o_ovf, o_unf
  );

  modport master (
    output i_pc, i_op, i_target, i_zero, i_stall,
    input  o_pc_add, o_halted, o_sp, o_ovf, o_unf
  );
endinterface

// File: rtl/pc_next_seq.sv
// Next-PC sequencer: picks the PC register's next load value from decoded control,
// keeping a LIFO return stack, a sticky halt state and sticky stack-error flags.
module pc_next_seq #(
  parameter int            AW       = 8,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  pc_next_seq_if.slave bus
);
  localparam int             SPW     = $clog2(DEPTH + 1);
  // Sized to the pointer range so the pointer indexes it without truncation;
  // entries at DEPTH and above are never written.
  localparam int             ENTRIES = 1 << SPW;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRZ  = 3'd2,
    OP_BRNZ = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_HALT = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e         r_state;
  state_e         w_stateNext;
  logic [AW-1:0]  r_stack [ENTRIES];
  logic [SPW-1:0] r_sp;
  logic           r_ovf;
  logic           r_unf;

  logic [AW-1:0]  w_pcInc;
  logic [AW-1:0]  w_pcNext;
  logic [AW-1:0]  w_top;
  logic [SPW-1:0] w_spDec;
  logic           w_push;
  logic           w_pop;
  logic           w_setOvf;
  logic           w_setUnf;

  assign w_pcInc = bus.i_pc + AW'(1);
  assign w_spDec = r_sp - SPW'(1);
  assign w_top   = r_stack[w_spDec];

  always_comb begin
    w_pcNext    = w_pcInc;
    w_stateNext = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_setOvf    = 1'b0;
    w_setUnf    = 1'b0;
    if (r_state == ST_HALTED || bus.i_stall) begin
      w_pcNext = bus.i_pc;
    end else begin
      case (op_e'(bus.i_op))
        OP_JMP:  w_pcNext = bus.i_target;
        OP_BRZ:  if (bus.i_zero)  w_pcNext = bus.i_target;
        OP_BRNZ: if (!bus.i_zero) w_pcNext = bus.i_target;
        OP_CALL: begin
          if (r_sp < SP_FULL) begin
            w_pcNext = bus.i_target;
            w_push   = 1'b1;
          end else begin
            w_setOvf = 1'b1;
          end
        end
        OP_RET: begin
          if (r_sp != '0) begin
            w_pcNext = w_top;
            w_pop    = 1'b1;
          end else begin
            w_setUnf = 1'b1;
          end
        end
        OP_HALT: begin
          w_pcNext    = bus.i_pc;
          w_stateNext = ST_HALTED;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_stateNext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) r_stack[i] <= '0;
    end else begin
      if (w_push) begin
        r_stack[r_sp] <= w_pcInc;
        r_sp          <= r_sp + SPW'(1);
      end else if (w_pop) begin
        r_sp <= w_spDec;
      end
      if (w_setOvf) r_ovf <= 1'b1;
      if (w_setUnf) r_unf <= 1'b1;
    end
  end

  // Reset overrides the next-PC mux combinationally so the PC register loads RESET_PC.
  assign bus.o_pc_add = rst ? w_pcNext : RESET_PC;
  assign bus.o_halted = (r_state == ST_HALTED);
  assign bus.o_sp     = r_sp;
  assign bus.o_ovf    = r_ovf;
  assign bus.o_unf    = r_unf;
endmodule

// File: tb/tb_pc_next_seq.sv
// Scoreboard bench for pc_next_seq: a queue-stack reference model pushes expected
// outputs when stimulus is driven; they are popped and compared once the DUT settles.
module tb_pc_next_seq;
  localparam int            AW       = 8;
  localparam int            DEPTH    = 4;
  localparam logic [AW-1:0] RESET_PC = 8'h00;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRZ  = 3'd2;
  localparam logic [2:0] OP_BRNZ = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef struct {
    logic [AW-1:0] pcAdd;
    int            sp;
    logic          halted;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pcReg;
  int            checkCount = 0;
  int            passCount  = 0;

  exp_t          expQ[$];
  logic [AW-1:0] mStack[$];
  logic          mHalted;
  logic          mOvf;
  logic          mUnf;
  logic [AW-1:0] mPc;

  pc_next_seq_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  pc_next_seq #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream PC register, closing the loop for the random run.
  always @(posedge clk) pcReg <= bus.o_pc_add;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: snapshot the visible state, decide the next PC, then advance.
  task automatic modelStep(input logic rstN, input logic [2:0] op, input logic [AW-1:0] pc,
                           input logic [AW-1:0] target, input logic zero, input logic stall);
    exp_t          e;
    logic [AW-1:0] inc;
    inc = pc + 8'd1;
    if (!rstN) begin
      mStack.delete();
      mHalted = 1'b0;
      mOvf    = 1'b0;
      mUnf    = 1'b0;
    end
    e.sp     = mStack.size();
    e.halted = mHalted;
    e.ovf    = mOvf;
    e.unf    = mUnf;
    if (!rstN) begin
      e.pcAdd = RESET_PC;
    end else if (mHalted || stall) begin
      e.pcAdd = pc;
    end else begin
      case (op)
        OP_JMP:  e.pcAdd = target;
        OP_BRZ:  e.pcAdd = zero ? target : inc;
        OP_BRNZ: e.pcAdd = zero ? inc : target;
        OP_CALL: begin
          if (mStack.size() < DEPTH) begin
            e.pcAdd = target;
            mStack.push_back(inc);
          end else begin
            e.pcAdd = inc;
            mOvf    = 1'b1;
          end
        end
        OP_RET: begin
          if (mStack.size() > 0) begin
            e.pcAdd = mStack.pop_back();
          end else begin
            e.pcAdd = inc;
            mUnf    = 1'b1;
          end
        end
        OP_HALT: begin
          e.pcAdd = pc;
          mHalted = 1'b1;
        end
        default: e.pcAdd = inc;
      endcase
    end
    mPc = e.pcAdd;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic rstN, input logic [2:0] op, input logic [AW-1:0] pcIn,
                               input logic [AW-1:0] target, input logic zero, input logic stall,
                               input bit closedLoop);
    logic [AW-1:0] pc;
    exp_t          e;
    @(negedge clk);
    pc = closedLoop ? pcReg : pcIn;
    if (closedLoop) checkOutput("pc_reg", 32'(pcReg), 32'(mPc));
    rst          = rstN;
    bus.i_pc     = pc;
    bus.i_op     = op;
    bus.i_target = target;
    bus.i_zero   = zero;
    bus.i_stall  = stall;
    modelStep(rstN, op, pc, target, zero, stall);
    #2;
    if (expQ.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = expQ.pop_front();
      checkOutput("pc_add", 32'(bus.o_pc_add), 32'(e.pcAdd));
      checkOutput("sp",     32'(bus.o_sp),     32'(e.sp));
      checkOutput("halted", 32'(bus.o_halted), 32'(e.halted));
      checkOutput("ovf",    32'(bus.o_ovf),    32'(e.ovf));
      checkOutput("unf",    32'(bus.o_unf),    32'(e.unf));
    end
  endtask

  // Drop reset between clock edges and confirm the state clears without a clock.
  task automatic asyncResetPulse();
    @(negedge clk);
    #3;
    rst = 1'b0;
    mStack.delete();
    mHalted = 1'b0;
    mOvf    = 1'b0;
    mUnf    = 1'b0;
    mPc     = RESET_PC;
    #1;
    checkOutput("async_sp",     32'(bus.o_sp),     32'd0);
    checkOutput("async_ovf",    32'(bus.o_ovf),    32'd0);
    checkOutput("async_unf",    32'(bus.o_unf),    32'd0);
    checkOutput("async_halted", 32'(bus.o_halted), 32'd0);
    checkOutput("async_pc_add", 32'(bus.o_pc_add), 32'(RESET_PC));
  endtask

  initial begin
    logic [2:0] rOp;
    rst          = 1'b0;
    bus.i_pc     = '0;
    bus.i_op     = OP_SEQ;
    bus.i_target = '0;
    bus.i_zero   = 1'b0;
    bus.i_stall  = 1'b0;
    mHalted      = 1'b0;
    mOvf         = 1'b0;
    mUnf         = 1'b0;
    mPc          = RESET_PC;

    $display("[TB] reset and wrap");
    applyStimulus(1'b0, OP_JMP, 8'h10, 8'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_SEQ, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] branches");
    applyStimulus(1'b1, OP_BRZ,  8'h10, 8'h40, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_BRZ,  8'h10, 8'h40, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_BRNZ, 8'h10, 8'h40, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_BRNZ, 8'h10, 8'h40, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JMP,  8'h10, 8'h40, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RSVD, 8'h10, 8'h40, 1'b0, 1'b0, 1'b0);

    $display("[TB] nested call/return");
    applyStimulus(1'b1, OP_CALL, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CALL, 8'h22, 8'h30, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_SEQ,  8'h30, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RET,  8'h31, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RET,  8'h23, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_SEQ,  8'h11, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CALL, 8'hFF, 8'h80, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RET,  8'h80, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] stall");
    applyStimulus(1'b1, OP_CALL, 8'h07, 8'h33, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_RET,  8'h07, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_SEQ,  8'h07, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] overflow and underflow");
    for (int k = 0; k <= DEPTH; k++)
      applyStimulus(1'b1, OP_CALL, 8'h60 + 8'(k), 8'h70, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_SEQ, 8'h70, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++)
      applyStimulus(1'b1, OP_RET, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RET, 8'h50, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b1, OP_SEQ, 8'(8'h51 + k), 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] closed-loop random run");
    for (int i = 0; i < 150; i++) begin
      if (i == 75) asyncResetPulse();
      rOp = 3'($urandom_range(0, 7));
      if (rOp == OP_HALT) rOp = OP_CALL;
      applyStimulus(1'b1, rOp, 8'h00, AW'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0), 1'b1);
    end

    $display("[TB] halt");
    applyStimulus(1'b1, OP_HALT, 8'h09, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JMP,  8'h09, 8'h44, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CALL, 8'h09, 8'h44, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RET,  8'h09, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_SEQ,  8'h09, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_SEQ,  8'h09, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/pc_next_seq.md
Name: pc_next_seq

Overview:
Next-PC sequencer sitting directly upstream of the PC register; its o_pc_add drives the PC register's PC_ADD input, and the PC register's o_PC returns as i_pc. Selects the next fetch address each cycle from decoded control: sequential increment, jump, conditional branch, call/return via an internal LIFO return stack, stall and halt. Holds the return stack, halt state and sticky stack-error flags.

Parameters:
AW, 8, address width (matches PC register)
DEPTH, 4, return-stack entries (>=1)
RESET_PC, 8'h00, o_pc_add value while reset is asserted

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-low (0 = in reset)
i_pc  input  AW  current PC (from PC register o_PC)
i_op  input  3  0 SEQ, 1 JMP, 2 BRZ, 3 BRNZ, 4 CALL, 5 RET, 6 HALT, 7 reserved (acts as SEQ)
i_target  input  AW  jump/branch/call destination
i_zero  input  1  ALU zero flag for BRZ/BRNZ
i_stall  input  1  hold PC, no state change
o_pc_add  output  AW  next PC, combinational, to PC register PC_ADD
o_halted  output  1  registered halt status
o_sp  output  $clog2(DEPTH+1)  return-stack occupancy 0..DEPTH
o_ovf  output  1  sticky: CALL attempted with stack full
o_unf  output  1  sticky: RET attempted with stack empty

Behaviour:
- Reset (rst=0, async): o_sp=0, all stack entries 0, o_halted=0, o_ovf=0, o_unf=0; o_pc_add=RESET_PC combinationally while rst=0.
- o_pc_add is combinational from i_pc, i_op, i_target, i_zero, i_stall, stack top, o_halted; zero-cycle latency so PC register loads it at the same edge.
- Priority: reset > halted > stall > i_op.
- o_halted=1 or i_stall=1: o_pc_add=i_pc; no stack/flag update regardless of i_op.
- pc+1 is modulo 2^AW (8'hFF -> 8'h00).
- SEQ/reserved: pc+1.
- JMP: i_target.
- BRZ: i_zero ? i_target : pc+1. BRNZ: i_zero ? pc+1 : i_target.
- CALL, o_sp<DEPTH: o_pc_add=i_target; at edge push pc+1 into entry[o_sp], o_sp+1.
- CALL, o_sp==DEPTH: call suppressed, o_pc_add=pc+1, no push, o_ovf<=1 at edge.
- RET, o_sp>0: o_pc_add=entry[o_sp-1]; at edge o_sp-1 (entry contents may remain).
- RET, o_sp==0: o_pc_add=pc+1, o_unf<=1 at edge.
- HALT: o_pc_add=i_pc; o_halted<=1 at edge; remains 1 until reset.
- o_ovf/o_unf cleared only by reset; never by subsequent ops.
- Return address pushed is of the CALL instruction's PC+1, including wrap (CALL at 8'hFF pushes 8'h00).
- Reset asserted mid-sequence: stack discarded immediately; after release first op sees o_sp=0.
- No simultaneous push/pop: one op per cycle.

Test Plan:
- Reset: rst=0 with i_op=JMP,i_target=8'h55 -> o_pc_add=8'h00, o_sp=0, flags 0; release, SEQ with i_pc=8'hFF -> o_pc_add=8'h00.
- Branches: i_pc=8'h10,i_target=8'h40: BRZ i_zero=1 -> 8'h40; BRZ i_zero=0 -> 8'h11; BRNZ i_zero=0 -> 8'h40; JMP -> 8'h40.
- Nested call/return: CALL from 8'h10->8'h20, CALL from 8'h22->8'h30 (o_sp=2), RET -> 8'h23, RET -> 8'h11, o_sp=0, no flags.
- Overflow/underflow: DEPTH+1 CALLs -> last gives o_pc_add=pc+1, o_ovf=1, o_sp=DEPTH; pop all then extra RET at i_pc=8'h50 -> 8'h51, o_unf=1; both flags stay 1 through 10 SEQ cycles.
- Stall/halt: i_stall=1 with CALL at i_pc=8'h07 -> o_pc_add=8'h07, o_sp unchanged; HALT at 8'h09 -> o_halted=1 next cycle, o_pc_add=8'h09 for any later op until rst=0.
- Random loop with PC register closed: 150 cycles random op/target/zero vs reference model; o_pc_add and PC match every cycle; rst=0 pulse mid-run clears o_sp and flags asynchronously.
